// File: rtl/tx_pkg.sv
// Shared TX definitions: preamble sequencer state encoding, segment lengths
// and IQ sample packing.
package tx_pkg;

  // IQ packing: I in the upper half, Q in the lower half.
  localparam int unsigned I_W  = 16;
  localparam int unsigned Q_W  = 16;
  localparam int unsigned IQ_W = I_W + Q_W;

  localparam int unsigned STF_LEN      = 16;
  localparam int unsigned LTF_LEN      = 64;
  localparam int unsigned PREAMBLE_LEN = 320;

  localparam int unsigned SAMP_CNT_W = 6;
  localparam int unsigned REP_CNT_W  = 4;

  typedef struct packed {
    logic [I_W-1:0] i;
    logic [Q_W-1:0] q;
  } iq_t;

  // The state names the segment that the next loaded word belongs to.
  typedef enum logic [2:0] {
    StIdle,
    StStf,
    StLtfGi,
    StLtf,
    StDrain
  } preamble_state_e;

endpackage

// File: rtl/preamble_addr_gen.sv
// Maps the sequencer state and counters onto the STF/LTF ROM addresses, the
// ROM select, and the end-of-period / end-of-segment / final-sample flags.
module preamble_addr_gen
  import tx_pkg::*;
#(
  parameter int unsigned STF_REPS = 10,
  parameter int unsigned LTF_REPS = 2
) (
  input  preamble_state_e         state,
  input  logic [SAMP_CNT_W-1:0]   samp_cnt,
  input  logic [REP_CNT_W-1:0]    rep_cnt,
  output logic [3:0]              stf_addr,
  output logic [SAMP_CNT_W-1:0]   ltf_addr,
  output logic                    sel_ltf,
  output logic                    period_end,
  output logic                    seg_end,
  output logic                    last
);

  // Decode addresses and end flags for the word about to be loaded.
  always_comb begin
    stf_addr   = '0;
    ltf_addr   = '0;
    sel_ltf    = 1'b0;
    period_end = 1'b0;
    seg_end    = 1'b0;
    last       = 1'b0;
    unique case (state)
      // In idle samp_cnt is 0, so STF[0] is already on the ROM output when
      // start arrives.
      StIdle, StStf: begin
        stf_addr   = samp_cnt[3:0];
        period_end = (state == StStf) && (samp_cnt[3:0] == 4'(STF_LEN - 1));
        seg_end    = period_end && (rep_cnt == REP_CNT_W'(STF_REPS - 1));
      end
      StLtfGi: begin
        ltf_addr   = samp_cnt;
        sel_ltf    = 1'b1;
        period_end = (samp_cnt == SAMP_CNT_W'(LTF_LEN - 1));
        seg_end    = period_end;
      end
      StLtf: begin
        ltf_addr   = samp_cnt;
        sel_ltf    = 1'b1;
        period_end = (samp_cnt == SAMP_CNT_W'(LTF_LEN - 1));
        seg_end    = period_end && (rep_cnt == REP_CNT_W'(LTF_REPS - 1));
        last       = seg_end;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/preamble_seq.sv
// Legacy 802.11a/g preamble sequencer: streams 10 STF periods followed by the
// LTF guard and LTF symbols from external ROMs through a registered
// valid/ready output stage.
module preamble_seq
  import tx_pkg::*;
#(
  parameter int unsigned STF_REPS   = 10,
  parameter int unsigned LTF_GI_LEN = 32,
  parameter int unsigned LTF_REPS   = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  abort,
  output logic [3:0]            stf_addr,
  input  logic [IQ_W-1:0]       stf_data,
  output logic [SAMP_CNT_W-1:0] ltf_addr,
  input  logic [IQ_W-1:0]       ltf_data,
  output logic [IQ_W-1:0]       out_iq,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  // out_last is tied to the final sample, so the segment lengths must add up.
  localparam int unsigned LoadsTotal = STF_REPS * STF_LEN + LTF_GI_LEN + LTF_REPS * LTF_LEN;
  if (LoadsTotal != PREAMBLE_LEN) begin : g_len_check
    $error("preamble_seq: segment lengths do not add up to PREAMBLE_LEN");
  end

  preamble_state_e         state_q, state_d;
  logic [SAMP_CNT_W-1:0]   samp_cnt_q, samp_cnt_d;
  logic [REP_CNT_W-1:0]    rep_cnt_q, rep_cnt_d;
  iq_t                     out_iq_q, out_iq_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic                    done_q, done_d;

  logic                    sel_ltf;
  logic                    period_end;
  logic                    seg_end;
  logic                    last_word;
  logic                    can_load;
  logic                    xfer;
  iq_t                     rom_word;

  preamble_addr_gen #(
    .STF_REPS (STF_REPS),
    .LTF_REPS (LTF_REPS)
  ) u_addr_gen (
    .state      (state_q),
    .samp_cnt   (samp_cnt_q),
    .rep_cnt    (rep_cnt_q),
    .stf_addr   (stf_addr),
    .ltf_addr   (ltf_addr),
    .sel_ltf    (sel_ltf),
    .period_end (period_end),
    .seg_end    (seg_end),
    .last       (last_word)
  );

  assign xfer     = out_valid_q & out_ready;
  // The output register may take a new word when empty or being emptied.
  assign can_load = ~out_valid_q | out_ready;
  assign rom_word = sel_ltf ? ltf_data : stf_data;

  // Next-state: segment walk, output register loading, handshake and abort.
  always_comb begin
    state_d     = state_q;
    samp_cnt_d  = samp_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    out_iq_d    = out_iq_q;
    out_valid_d = out_valid_q & ~out_ready;
    out_last_d  = out_last_q & ~xfer;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          out_iq_d    = rom_word;
          out_valid_d = 1'b1;
          samp_cnt_d  = samp_cnt_q + SAMP_CNT_W'(1);
          state_d     = StStf;
        end
      end
      StStf, StLtfGi, StLtf: begin
        if (can_load) begin
          out_iq_d    = rom_word;
          out_valid_d = 1'b1;
          out_last_d  = last_word;
          if (!period_end) begin
            samp_cnt_d = samp_cnt_q + SAMP_CNT_W'(1);
          end else begin
            samp_cnt_d = '0;
            if (state_q == StStf) begin
              if (seg_end) begin
                // The guard interval is the tail of the LTF symbol.
                samp_cnt_d = SAMP_CNT_W'(LTF_LEN - LTF_GI_LEN);
                rep_cnt_d  = '0;
                state_d    = StLtfGi;
              end else begin
                rep_cnt_d = rep_cnt_q + REP_CNT_W'(1);
              end
            end else if (state_q == StLtfGi) begin
              state_d = StLtf;
            end else begin
              if (seg_end) begin
                rep_cnt_d = '0;
                state_d   = StDrain;
              end else begin
                rep_cnt_d = rep_cnt_q + REP_CNT_W'(1);
              end
            end
          end
        end
      end
      StDrain: begin
        if (xfer) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over everything; the last word stays in out_iq but is no
    // longer valid.
    if (abort) begin
      state_d     = StIdle;
      samp_cnt_d  = '0;
      rep_cnt_d   = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      done_d      = 1'b0;
    end
  end

  // State, counters and output register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      samp_cnt_q  <= '0;
      rep_cnt_q   <= '0;
      out_iq_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      samp_cnt_q  <= samp_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      out_iq_q    <= out_iq_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  assign out_iq    = out_iq_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign done      = done_q;
  assign busy      = (state_q != StIdle);

endmodule
